// File: rtl/dual_issue_fetch_queue.sv
// dual_issue_fetch_queue
//   Instruction buffer between the icache/PC stage and the dual-issue decode
//   stage. It accepts one fetched {instr, pc} per cycle into a circular buffer
//   and presents the two oldest entries as slot 0 / slot 1. Decode retires
//   0, 1 or 2 entries per cycle. A redirect flushes the whole buffer.
//
//   Optional feature macro: DUAL_ISSUE_FETCH_QUEUE_BYPASS_EN
//     When defined, an enqueue into an empty queue is shown on slot 0 in the
//     same cycle, and a same-cycle single dequeue consumes it without a write.
//
//   Ports
//     clk_i        clock
//     reset_n_i    synchronous active-low reset
//     enq_v_i      fetch valid
//     enq_instr_i  fetched instruction
//     enq_pc_i     word PC of fetched instruction
//     enq_ready_o  queue can accept this cycle (registered state only)
//     slot_v_o     bit0: slot 0 valid; bit1: slot 1 valid and sequential
//     instr0_o     oldest instruction
//     instr1_o     second-oldest instruction
//     pc0_o        PC of slot 0
//     pc1_o        PC of slot 1
//     deq_count_i  entries consumed this cycle (0, 1, 2; 3 is illegal)
//     flush_i      discard all entries
//     count_o      current occupancy

module dual_issue_fetch_queue #(
  parameter int unsigned depth_p       = 8,
  parameter int unsigned instr_width_p = 32,
  parameter int unsigned pc_width_p    = 22
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       enq_v_i,
  input  logic [instr_width_p-1:0]   enq_instr_i,
  input  logic [pc_width_p-1:0]      enq_pc_i,
  output logic                       enq_ready_o,
  output logic [1:0]                 slot_v_o,
  output logic [instr_width_p-1:0]   instr0_o,
  output logic [instr_width_p-1:0]   instr1_o,
  output logic [pc_width_p-1:0]      pc0_o,
  output logic [pc_width_p-1:0]      pc1_o,
  input  logic [1:0]                 deq_count_i,
  input  logic                       flush_i,
  output logic [$clog2(depth_p):0]   count_o
);

  localparam int unsigned PtrW = $clog2(depth_p);
  localparam int unsigned CntW = PtrW + 1;

  // Storage
  logic [instr_width_p-1:0] instr_mem_q [depth_p];
  logic [pc_width_p-1:0]    pc_mem_q    [depth_p];

  // State
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Combinational helpers
  logic [PtrW-1:0] rd_ptr1_c;
  logic            enq_fire_c;
  logic            wr_en_c;
  logic            bypass_c;
  logic            bypass_take_c;
  logic            seq_c;
  logic [1:0]      deq_legal_c;
  logic [1:0]      pop_c;

  assign rd_ptr1_c   = rd_ptr_q + PtrW'(1);
  assign enq_ready_o = (count_q < CntW'(depth_p));
  assign enq_fire_c  = enq_v_i && enq_ready_o;
  assign count_o     = count_q;

  // Slot 1 is only pairable when it directly follows slot 0 in program order
  assign seq_c = (pc_mem_q[rd_ptr1_c] == (pc_mem_q[rd_ptr_q] + pc_width_p'(1)));

`ifdef DUAL_ISSUE_FETCH_QUEUE_BYPASS_EN
  assign bypass_c = enq_v_i && (count_q == '0);
`else
  assign bypass_c = 1'b0;
`endif

  // Slot presentation
  always_comb begin
    slot_v_o = 2'b00;
    instr0_o = '0;
    pc0_o    = '0;
    instr1_o = '0;
    pc1_o    = '0;
    if (bypass_c) begin
      slot_v_o = 2'b01;
      instr0_o = enq_instr_i;
      pc0_o    = enq_pc_i;
    end else if (count_q != '0) begin
      slot_v_o[0] = 1'b1;
      instr0_o    = instr_mem_q[rd_ptr_q];
      pc0_o       = pc_mem_q[rd_ptr_q];
      if ((count_q >= CntW'(2)) && seq_c) begin
        slot_v_o[1] = 1'b1;
        instr1_o    = instr_mem_q[rd_ptr1_c];
        pc1_o       = pc_mem_q[rd_ptr1_c];
      end
    end
  end

  // Clamp the retire count to what the slots actually offer
  always_comb begin
    deq_legal_c = 2'd0;
    if ((deq_count_i == 2'd2) && slot_v_o[1]) begin
      deq_legal_c = 2'd2;
    end else if ((deq_count_i != 2'd0) && slot_v_o[0]) begin
      deq_legal_c = 2'd1;
    end
  end

  // Next-state: pointers and occupancy
  always_comb begin
    // A bypassed entry consumed this cycle is never written
    bypass_take_c = bypass_c && (deq_legal_c == 2'd1);
    wr_en_c       = enq_fire_c && !bypass_take_c && !flush_i;
    pop_c         = bypass_take_c ? 2'd0 : deq_legal_c;
    rd_ptr_d      = rd_ptr_q + PtrW'(pop_c);
    wr_ptr_d      = wr_ptr_q + (wr_en_c ? PtrW'(1) : PtrW'(0));
    count_d       = count_q + CntW'(wr_en_c) - CntW'(pop_c);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write
  always_ff @(posedge clk_i) begin
    if (reset_n_i && wr_en_c) begin
      instr_mem_q[wr_ptr_q] <= enq_instr_i;
      pc_mem_q[wr_ptr_q]    <= enq_pc_i;
    end
  end

  // Decode must never retire more than the slots present
  assert property (@(posedge clk_i) disable iff (!reset_n_i || flush_i)
                   deq_count_i <= deq_legal_c);

endmodule

// File: tb/tb_dual_issue_fetch_queue.sv
// Bench for dual_issue_fetch_queue: a queue of expected PCs is pushed on each
// accepted enqueue and popped when decode retires entries; every cycle the
// presented slots, occupancy and ready are compared with that queue.
module tb_dual_issue_fetch_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned IW    = 32;
  localparam int unsigned PW    = 22;
  localparam int unsigned CW    = 4;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          enq_v_i;
  logic [IW-1:0] enq_instr_i;
  logic [PW-1:0] enq_pc_i;
  logic          enq_ready_o;
  logic [1:0]    slot_v_o;
  logic [IW-1:0] instr0_o;
  logic [IW-1:0] instr1_o;
  logic [PW-1:0] pc0_o;
  logic [PW-1:0] pc1_o;
  logic [1:0]    deq_count_i;
  logic          flush_i;
  logic [CW-1:0] count_o;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] sb_q [$];

  always #5 clk_i = ~clk_i;

  dual_issue_fetch_queue #(
    .depth_p       (DEPTH),
    .instr_width_p (IW),
    .pc_width_p    (PW)
  ) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .enq_v_i     (enq_v_i),
    .enq_instr_i (enq_instr_i),
    .enq_pc_i    (enq_pc_i),
    .enq_ready_o (enq_ready_o),
    .slot_v_o    (slot_v_o),
    .instr0_o    (instr0_o),
    .instr1_o    (instr1_o),
    .pc0_o       (pc0_o),
    .pc1_o       (pc1_o),
    .deq_count_i (deq_count_i),
    .flush_i     (flush_i),
    .count_o     (count_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] instr_of(input logic [PW-1:0] pc);
    return {10'h3C5, pc};
  endfunction

  // Reset with activity on the inputs, then check the cleared state
  task automatic do_reset(input string tag);
    reset_n_i   = 1'b0;
    enq_v_i     = 1'b1;
    enq_pc_i    = 22'h3AB;
    enq_instr_i = instr_of(22'h3AB);
    deq_count_i = 2'd1;
    flush_i     = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i   = 1'b1;
    enq_v_i     = 1'b0;
    deq_count_i = 2'd0;
    sb_q.delete();
    #1;
    check({tag, ".count"}, 32'(count_o), 32'd0);
    check({tag, ".slot_v"}, 32'(slot_v_o), 32'd0);
    check({tag, ".ready"}, 32'(enq_ready_o), 32'd1);
    check({tag, ".pc0"}, 32'(pc0_o), 32'd0);
    check({tag, ".instr0"}, instr0_o, 32'd0);
  endtask

  // One clock: drive, compare presented state, update scoreboard, advance
  task automatic cycle(input logic ev, input logic [PW-1:0] pc, input logic [1:0] want,
                       input logic fl, input string tag);
    logic       bp, s0, s1;
    logic [1:0] d;
    logic [PW-1:0] e0, e1;
    bp = 1'b0;
`ifdef DUAL_ISSUE_FETCH_QUEUE_BYPASS_EN
    bp = ev && (sb_q.size() == 0);
`endif
    s0 = (sb_q.size() >= 1) || bp;
    s1 = 1'b0;
    if (sb_q.size() >= 2) s1 = (sb_q[1] == sb_q[0] + PW'(1));
    d = (want == 2'd2 && s1) ? 2'd2 : ((want != 2'd0 && s0) ? 2'd1 : 2'd0);

    enq_v_i     = ev;
    enq_pc_i    = pc;
    enq_instr_i = instr_of(pc);
    deq_count_i = d;
    flush_i     = fl;
    #1;
    check({tag, ".ready"}, 32'(enq_ready_o), 32'(sb_q.size() < DEPTH));
    check({tag, ".count"}, 32'(count_o), 32'(sb_q.size()));
    check({tag, ".slot_v"}, 32'(slot_v_o), 32'({s1, s0}));

    if (!fl && ev && sb_q.size() < DEPTH) sb_q.push_back(pc);
    if (s0) begin
      e0 = sb_q[0];
      check({tag, ".pc0"}, 32'(pc0_o), 32'(e0));
      check({tag, ".instr0"}, instr0_o, instr_of(e0));
    end
    if (s1) begin
      e1 = sb_q[1];
      check({tag, ".pc1"}, 32'(pc1_o), 32'(e1));
      check({tag, ".instr1"}, instr1_o, instr_of(e1));
    end
    if (fl) sb_q.delete();
    else repeat (int'(d)) void'(sb_q.pop_front());

    @(posedge clk_i);
    #1;
    enq_v_i     = 1'b0;
    deq_count_i = 2'd0;
    flush_i     = 1'b0;
  endtask

  initial begin
    reset_n_i   = 1'b0;
    enq_v_i     = 1'b0;
    enq_pc_i    = '0;
    enq_instr_i = '0;
    deq_count_i = 2'd0;
    flush_i     = 1'b0;

    do_reset("rst");

    // Sequential pair
    cycle(1'b1, 22'h100, 2'd0, 1'b0, "pair_a");
    cycle(1'b1, 22'h101, 2'd0, 1'b0, "pair_b");
    cycle(1'b0, 22'h0,   2'd2, 1'b0, "pair_deq");
    check("pair_empty.count", 32'(count_o), 32'd0);

    // Non-sequential pair is never paired
    cycle(1'b1, 22'h100, 2'd0, 1'b0, "nseq_a");
    cycle(1'b1, 22'h200, 2'd0, 1'b0, "nseq_b");
    cycle(1'b0, 22'h0,   2'd1, 1'b0, "nseq_deq");
    cycle(1'b0, 22'h0,   2'd1, 1'b0, "nseq_last");

    // Fill to full, dropped enqueue, no accept on full even with dequeue
    for (int i = 0; i < 8; i++) cycle(1'b1, PW'(32'h300 + i), 2'd0, 1'b0, "fill");
    cycle(1'b1, 22'h3FF, 2'd0, 1'b0, "full_drop");
    cycle(1'b1, 22'h3FE, 2'd2, 1'b0, "full_deq");
    check("after_full.count", 32'(count_o), 32'd6);
    check("after_full.ready", 32'(enq_ready_o), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 22'h0, 2'd2, 1'b0, "drain_full");

    // Streaming with alternating retire widths across pointer wrap
    for (int i = 0; i < 20; i++)
      cycle(1'b1, PW'(32'h400 + i), (i % 2 == 0) ? 2'd2 : 2'd1, 1'b0, "stream");
    for (int i = 0; i < 10; i++) cycle(1'b0, 22'h0, 2'd2, 1'b0, "drain_stream");

    // Flush with concurrent enqueue and dequeue
    for (int i = 0; i < 5; i++) cycle(1'b1, PW'(32'h500 + i), 2'd0, 1'b0, "pre_flush");
    cycle(1'b1, 22'h5FF, 2'd2, 1'b1, "flush");
    cycle(1'b1, 22'h600, 2'd0, 1'b0, "post_flush");
    cycle(1'b0, 22'h0,   2'd1, 1'b0, "post_flush_deq");

    // Enqueue into empty queue with single retire requested
    cycle(1'b1, 22'h40, 2'd1, 1'b0, "byp");
    cycle(1'b0, 22'h0,  2'd1, 1'b0, "byp_after");
    cycle(1'b0, 22'h0,  2'd0, 1'b0, "byp_idle");

    // Reset in the middle of traffic
    for (int i = 0; i < 3; i++) cycle(1'b1, PW'(32'h700 + i), 2'd0, 1'b0, "pre_rst");
    do_reset("mid_rst");
    cycle(1'b1, 22'h800, 2'd0, 1'b0, "post_rst");
    cycle(1'b0, 22'h0,   2'd1, 1'b0, "post_rst_deq");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
